// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_ctrl
// Brief    : Halts the pipeline, borrows the rs read port and streams all
//            general-purpose registers MSB-first as bytes to the debug UART.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_dump_req,
    input  logic               i_halted,
    output logic               o_halt_req,
    output logic               o_busy,
    output logic               o_done,
    input  logic [NB_ADDR-1:0] i_dec_addr_rs,
    output logic [NB_ADDR-1:0] o_rf_addr_rs,
    input  logic [NB_DATA-1:0] i_rf_data_rs,
    output logic [7:0]         o_byte,
    output logic               o_byte_valid,
    input  logic               i_byte_ready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [NB_ADDR-1:0] c_last_idx = NB_ADDR'(N_REGS - 1);

    state_t             r_state;
    logic [NB_ADDR-1:0] r_reg_idx;
    logic [1:0]         r_byte_cnt;
    logic [NB_DATA-1:0] r_word;

    state_t             w_state_nxt;
    logic [NB_ADDR-1:0] w_reg_idx_nxt;
    logic [1:0]         w_byte_cnt_nxt;
    logic [NB_DATA-1:0] w_word_nxt;
    logic [NB_DATA-1:0] w_word_shift;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_reg_idx  <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_reg_idx  <= w_reg_idx_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_word     <= w_word_nxt;
        end
    end

    // Current byte sits in the top 8 bits after shifting out already-sent bytes
    assign w_word_shift = r_word << {r_byte_cnt, 3'b000};

    always_comb begin
        w_state_nxt    = r_state;
        w_reg_idx_nxt  = r_reg_idx;
        w_byte_cnt_nxt = r_byte_cnt;
        w_word_nxt     = r_word;
        o_halt_req     = 1'b0;
        o_busy         = 1'b1;
        o_done         = 1'b0;
        o_byte         = 8'h00;
        o_byte_valid   = 1'b0;
        o_rf_addr_rs   = i_dec_addr_rs;

        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_dump_req) begin
                    w_state_nxt    = ST_HALT;
                    w_reg_idx_nxt  = '0;
                    w_byte_cnt_nxt = '0;
                end
            end

            ST_HALT: begin
                o_halt_req = 1'b1;
                if (i_halted) begin
                    w_state_nxt = ST_LATCH;
                end
            end

            ST_LATCH: begin
                o_halt_req     = 1'b1;
                o_rf_addr_rs   = r_reg_idx;
                w_byte_cnt_nxt = '0;
                if (!i_halted) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_word_nxt  = i_rf_data_rs;
                    w_state_nxt = ST_SEND;
                end
            end

            ST_SEND: begin
                o_halt_req = 1'b1;
                o_byte     = w_word_shift[NB_DATA-1 -: 8];
                // Losing the halt withdraws the byte and restarts this register
                if (!i_halted) begin
                    w_state_nxt    = ST_HALT;
                    w_byte_cnt_nxt = '0;
                end else begin
                    o_byte_valid = 1'b1;
                    if (i_byte_ready) begin
                        if (r_byte_cnt != 2'd3) begin
                            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        end else if (r_reg_idx == c_last_idx) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_reg_idx_nxt = r_reg_idx + 1'b1;
                            w_state_nxt   = ST_LATCH;
                        end
                    end
                end
            end

            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_ctrl
// Brief    : Scoreboard bench for regfile_dump_ctrl with a behavioural
//            register file and randomized consumer backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_ctrl;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int N_REGS  = 32;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               i_dump_req;
    logic               i_halted;
    logic               o_halt_req;
    logic               o_busy;
    logic               o_done;
    logic [NB_ADDR-1:0] i_dec_addr_rs;
    logic [NB_ADDR-1:0] o_rf_addr_rs;
    logic [NB_DATA-1:0] i_rf_data_rs;
    logic [7:0]         o_byte;
    logic               o_byte_valid;
    logic               i_byte_ready;

    logic [NB_DATA-1:0] rf [N_REGS];
    logic [7:0]         exp_q [$];

    int  n_vec    = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    int  acc_cnt  = 0;
    int  done_cnt = 0;
    int  done_cyc = -1;
    int  fv_cyc   = -1;
    bit  rand_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign i_rf_data_rs = rf[o_rf_addr_rs];

    regfile_dump_ctrl #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .N_REGS  (N_REGS)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_dump_req    (i_dump_req),
        .i_halted      (i_halted),
        .o_halt_req    (o_halt_req),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .i_dec_addr_rs (i_dec_addr_rs),
        .o_rf_addr_rs  (o_rf_addr_rs),
        .i_rf_data_rs  (i_rf_data_rs),
        .o_byte        (o_byte),
        .o_byte_valid  (o_byte_valid),
        .i_byte_ready  (i_byte_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a dump emits every register in index order, 4 bytes each, MSB first
    task automatic start_dump(output int p);
        for (int i = 0; i < N_REGS; i++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(rf[i][31-8*b -: 8]);
            end
        end
        p = cyc;
        i_dump_req = 1'b1;
        tick();
        i_dump_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_acc(input int target, input bit need_valid);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (acc_cnt >= target && (!need_valid || o_byte_valid)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("acc_timeout", 32'd0, 32'd1);
    endtask

    // Consumer readiness
    initial begin
        i_byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake
    initial begin
        logic       pv, pr;
        logic [7:0] pb;
        pv = 1'b0; pr = 1'b0; pb = 8'h00;
        forever begin
            @(negedge clk);
            if (i_reset !== 1'b1) begin
                if (pv && !pr && o_byte_valid) check("hold_byte", 32'(o_byte), 32'(pb));
                if (o_byte_valid) begin
                    if (fv_cyc < 0) fv_cyc = cyc;
                    check("rs_passthru", 32'(o_rf_addr_rs), 32'(i_dec_addr_rs));
                end
                if (o_byte_valid && i_byte_ready) begin
                    if (exp_q.size() == 0) check("extra_byte", 32'(o_byte), 32'hFFFF_FFFF);
                    else                   check("byte", 32'(o_byte), 32'(exp_q.pop_front()));
                    acc_cnt++;
                end
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_q_empty", 32'(exp_q.size()), 32'd0);
                    check("halt_with_done", 32'(o_halt_req), 32'd0);
                end
            end
            pv = o_byte_valid;
            pr = i_byte_ready;
            pb = o_byte;
        end
    end

    initial begin
        int p, d0, a0;

        for (int i = 0; i < N_REGS; i++) rf[i] = 32'hA500_0000 + 32'(i);
        i_reset       = 1'b1;
        i_dump_req    = 1'b0;
        i_halted      = 1'b0;
        i_dec_addr_rs = 5'd7;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_halt_req", 32'(o_halt_req), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_valid", 32'(o_byte_valid), 32'd0);
        check("rst_byte", 32'(o_byte), 32'd0);
        check("rst_rs_addr", 32'(o_rf_addr_rs), 32'd7);
        tick();
        i_reset = 1'b0;
        tick();

        // Full dump, ready held, halt confirmed 4 cycles after the request
        fv_cyc = -1;
        d0 = done_cnt;
        start_dump(p);
        @(negedge clk);
        check("halt_req_on", 32'(o_halt_req), 32'd1);
        check("busy_on", 32'(o_busy), 32'd1);
        repeat (3) tick();
        i_halted = 1'b1;
        wait_done(400);
        check("first_valid_cyc", 32'(fv_cyc - p), 32'd6);
        check("done_cyc", 32'(done_cyc - p), 32'd165);
        check("done_once_1", 32'(done_cnt - d0), 32'd1);
        @(negedge clk);
        check("idle_busy_1", 32'(o_busy), 32'd0);
        check("idle_halt_1", 32'(o_halt_req), 32'd0);
        tick();
        i_halted = 1'b0;
        tick();

        // Backpressure
        rand_ready = 1'b1;
        i_halted   = 1'b1;
        d0 = done_cnt;
        start_dump(p);
        wait_done(2000);
        check("done_once_2", 32'(done_cnt - d0), 32'd1);
        repeat (2) tick();

        // Halt loss during byte 2 of r5
        rand_ready = 1'b0;
        rf[5] = 32'h1122_3344;
        d0 = done_cnt;
        a0 = acc_cnt;
        start_dump(p);
        wait_acc(a0 + 22, 1'b0);
        i_halted = 1'b0;
        // r5 restarts from byte 0, so its first two bytes are sent again
        exp_q.push_front(rf[5][23:16]);
        exp_q.push_front(rf[5][31:24]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hl_valid_low", 32'(o_byte_valid), 32'd0);
            check("hl_halt_req", 32'(o_halt_req), 32'd1);
            tick();
        end
        i_halted = 1'b1;
        wait_done(400);
        check("done_once_3", 32'(done_cnt - d0), 32'd1);
        repeat (2) tick();

        // Reset mid-dump during r10, then a fresh dump from r0
        rand_ready = 1'b1;
        d0 = done_cnt;
        a0 = acc_cnt;
        start_dump(p);
        wait_acc(a0 + 41, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_valid", 32'(o_byte_valid), 32'd0);
        check("mid_rst_halt", 32'(o_halt_req), 32'd0);
        check("mid_rst_byte", 32'(o_byte), 32'd0);
        repeat (3) tick();
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        start_dump(p);
        wait_done(2000);
        check("done_once_4", 32'(done_cnt - d0), 32'd1);
        repeat (2) tick();

        // Request during SEND is ignored
        d0 = done_cnt;
        a0 = acc_cnt;
        start_dump(p);
        wait_acc(a0 + 10, 1'b1);
        i_dump_req = 1'b1;
        tick();
        i_dump_req = 1'b0;
        wait_done(2000);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stay_idle", 32'(o_busy), 32'd0);
        end
        check("done_once_5", 32'(done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
